// File: rtl/core_scoreboard.sv
// Issue-side hazard controller: tracks in-flight x/f destinations, holds issue on RAW/WAW/full, drains before fences.
// Optional build macro CORE_SB_BYPASS_EN: a source cleared by writeback in the same cycle is not a RAW hazard.
module core_scoreboard #(
  parameter int unsigned MAX_INFLIGHT = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ISSUE_VALID,
  output logic             ISSUE_READY,
  input  logic             ISSUE_FENCE,
  input  logic             RS1_EN,
  input  logic             RS1_FP,
  input  logic [4:0]       RS1_NUM,
  input  logic             RS2_EN,
  input  logic             RS2_FP,
  input  logic [4:0]       RS2_NUM,
  input  logic             RD_EN,
  input  logic             FRD_EN,
  input  logic [4:0]       RD_NUM,
  input  logic             WB_VALID,
  input  logic [4:0]       WB_NUM,
  input  logic             FWB_VALID,
  input  logic [4:0]       FWB_NUM,
  output logic             STALL_RAW,
  output logic             STALL_WAW,
  output logic [CNT_W-1:0] INFLIGHT,
  output logic             SB_ERR
);

  localparam int unsigned NREG = 32;
  localparam int unsigned SUMW = CNT_W + 1;

  typedef enum logic {S_RUN, S_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [NREG-1:0]   x_busy, f_busy;
  logic [NREG-1:0]   x_clr, f_clr, x_set, f_set;
  logic [NREG-1:0]   x_haz, f_haz;
  logic              rs1_haz, rs2_haz, raw, waw, full, fence_wait;
  logic              x_dst, has_dst, accept;
  logic              wb_hit_x, wb_hit_f, wb_err;
  logic [SUMW-1:0]   cnt_sum, cnt_dec;
  logic              underflow;
  logic [CNT_W-1:0]  cnt_nxt;

  // Writeback clear masks; x0 is never tracked
  always_comb begin
    x_clr = '0;
    f_clr = '0;
    if (WB_VALID && (WB_NUM != 5'd0)) x_clr[WB_NUM] = 1'b1;
    if (FWB_VALID)                    f_clr[FWB_NUM] = 1'b1;
  end

`ifdef CORE_SB_BYPASS_EN
  assign x_haz = x_busy & ~x_clr;
  assign f_haz = f_busy & ~f_clr;
`else
  assign x_haz = x_busy;
  assign f_haz = f_busy;
`endif

  assign rs1_haz    = RS1_EN && (RS1_FP ? f_haz[RS1_NUM] : ((RS1_NUM != 5'd0) && x_haz[RS1_NUM]));
  assign rs2_haz    = RS2_EN && (RS2_FP ? f_haz[RS2_NUM] : ((RS2_NUM != 5'd0) && x_haz[RS2_NUM]));
  assign raw        = rs1_haz || rs2_haz;
  assign waw        = (RD_EN && x_busy[RD_NUM]) || (FRD_EN && f_busy[RD_NUM]);
  assign x_dst      = RD_EN && (RD_NUM != 5'd0);
  assign has_dst    = x_dst || FRD_EN;
  assign full       = (INFLIGHT == CNT_W'(MAX_INFLIGHT)) && has_dst;
  assign fence_wait = ISSUE_FENCE && (INFLIGHT != '0);

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (ISSUE_VALID && fence_wait) state_nxt = S_DRAIN;
      S_DRAIN: if (INFLIGHT == '0)            state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  // Output logic
  always_comb begin
    ISSUE_READY = 1'b0;
    if (state == S_RUN) ISSUE_READY = !raw && !waw && !full && !fence_wait;
  end

  assign accept = ISSUE_VALID && ISSUE_READY;

  always_comb begin
    x_set = '0;
    f_set = '0;
    if (accept && x_dst)  x_set[RD_NUM] = 1'b1;
    if (accept && FRD_EN) f_set[RD_NUM] = 1'b1;
  end

  assign wb_hit_x = WB_VALID && (WB_NUM != 5'd0) && x_busy[WB_NUM];
  assign wb_hit_f = FWB_VALID && f_busy[FWB_NUM];
  assign wb_err   = (WB_VALID && (WB_NUM != 5'd0) && !x_busy[WB_NUM]) ||
                    (FWB_VALID && !f_busy[FWB_NUM]);

  // Net in-flight update: old + issue - wb - fwb
  assign cnt_sum   = SUMW'(INFLIGHT) + SUMW'(accept && has_dst);
  assign cnt_dec   = SUMW'(wb_hit_x) + SUMW'(wb_hit_f);
  assign underflow = cnt_sum < cnt_dec;
  assign cnt_nxt   = underflow ? '0 : CNT_W'(cnt_sum - cnt_dec);

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= S_RUN;
    else        state <= state_nxt;
  end

  // Busy bits (set wins over same-cycle clear), count, stall flags, sticky error
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      x_busy    <= '0;
      f_busy    <= '0;
      INFLIGHT  <= '0;
      STALL_RAW <= 1'b0;
      STALL_WAW <= 1'b0;
      SB_ERR    <= 1'b0;
    end else begin
      x_busy    <= (x_busy & ~x_clr) | x_set;
      f_busy    <= (f_busy & ~f_clr) | f_set;
      INFLIGHT  <= cnt_nxt;
      STALL_RAW <= ISSUE_VALID && !ISSUE_READY && raw;
      STALL_WAW <= ISSUE_VALID && !ISSUE_READY && waw;
      if (wb_err || underflow) SB_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_scoreboard.sv
// Directed self-checking bench for core_scoreboard (both CORE_SB_BYPASS_EN builds).
module tb_core_scoreboard;

  logic       CLK, RST_N;
  logic       ISSUE_VALID, ISSUE_READY, ISSUE_FENCE;
  logic       RS1_EN, RS1_FP, RS2_EN, RS2_FP;
  logic [4:0] RS1_NUM, RS2_NUM, RD_NUM, WB_NUM, FWB_NUM;
  logic       RD_EN, FRD_EN, WB_VALID, FWB_VALID;
  logic       STALL_RAW, STALL_WAW, SB_ERR;
  logic [3:0] INFLIGHT;

  int n_checks = 0;
  int n_err    = 0;

  core_scoreboard #(.MAX_INFLIGHT(8), .CNT_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_READY(ISSUE_READY), .ISSUE_FENCE(ISSUE_FENCE),
    .RS1_EN(RS1_EN), .RS1_FP(RS1_FP), .RS1_NUM(RS1_NUM),
    .RS2_EN(RS2_EN), .RS2_FP(RS2_FP), .RS2_NUM(RS2_NUM),
    .RD_EN(RD_EN), .FRD_EN(FRD_EN), .RD_NUM(RD_NUM),
    .WB_VALID(WB_VALID), .WB_NUM(WB_NUM), .FWB_VALID(FWB_VALID), .FWB_NUM(FWB_NUM),
    .STALL_RAW(STALL_RAW), .STALL_WAW(STALL_WAW), .INFLIGHT(INFLIGHT), .SB_ERR(SB_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    ISSUE_VALID = 0; ISSUE_FENCE = 0;
    RS1_EN = 0; RS1_FP = 0; RS1_NUM = 0;
    RS2_EN = 0; RS2_FP = 0; RS2_NUM = 0;
    RD_EN = 0; FRD_EN = 0; RD_NUM = 0;
    WB_VALID = 0; WB_NUM = 0; FWB_VALID = 0; FWB_NUM = 0;
  endtask

  task automatic ins(input logic fp, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic xd, input logic fd, input logic [4:0] rd);
    ISSUE_VALID = 1; ISSUE_FENCE = 0;
    RS1_EN = 1; RS1_FP = fp; RS1_NUM = rs1;
    RS2_EN = 1; RS2_FP = fp; RS2_NUM = rs2;
    RD_EN = xd; FRD_EN = fd; RD_NUM = rd;
  endtask

  initial begin
    CLK = 0;
    RST_N = 0;
    idle();
    tick(); tick();
    RST_N = 1;

    // 1 reset state; add x1,x2,x3 presented
    ins(0, 5'd2, 5'd3, 1, 0, 5'd1);
    settle();
    chk("rst_ready", 32'(ISSUE_READY), 32'd1);
    chk("rst_inflight", 32'(INFLIGHT), 32'd0);
    chk("rst_err", 32'(SB_ERR), 32'd0);
    chk("rst_stall", 32'({STALL_RAW, STALL_WAW}), 32'd0);
    idle();

    // 2 RAW on f3
    ins(1, 5'd1, 5'd2, 0, 1, 5'd3);
    tick();
    chk("raw_inflight1", 32'(INFLIGHT), 32'd1);
    ins(1, 5'd3, 5'd4, 0, 1, 5'd5);
    settle();
    chk("raw_ready0", 32'(ISSUE_READY), 32'd0);
    tick();
    chk("raw_stall", 32'(STALL_RAW), 32'd1);
    chk("raw_nowaw", 32'(STALL_WAW), 32'd0);
    FWB_VALID = 1; FWB_NUM = 5'd3;
    settle();
`ifdef CORE_SB_BYPASS_EN
    chk("raw_ready_wb", 32'(ISSUE_READY), 32'd1);
    tick();
    FWB_VALID = 0;
    ISSUE_VALID = 0;
    chk("raw_stall_clr", 32'(STALL_RAW), 32'd0);
`else
    chk("raw_ready_wb", 32'(ISSUE_READY), 32'd0);
    tick();
    FWB_VALID = 0;
    settle();
    chk("raw_ready_next", 32'(ISSUE_READY), 32'd1);
    chk("raw_stall_wb", 32'(STALL_RAW), 32'd1);
    tick();
    ISSUE_VALID = 0;
`endif
    chk("raw_inflight_after", 32'(INFLIGHT), 32'd1);
    idle();
    FWB_VALID = 1; FWB_NUM = 5'd5;
    tick();
    idle();
    chk("raw_drained", 32'(INFLIGHT), 32'd0);
    chk("raw_err", 32'(SB_ERR), 32'd0);

    // 3 full window: loads x1..x8 with rs1=x0
    for (int i = 1; i <= 8; i++) begin
      ins(0, 5'd0, 5'd0, 1, 0, 5'(i));
      tick();
    end
    chk("full_inflight8", 32'(INFLIGHT), 32'd8);
    ins(0, 5'd0, 5'd0, 1, 0, 5'd9);
    settle();
    chk("full_ready0", 32'(ISSUE_READY), 32'd0);
    WB_VALID = 1; WB_NUM = 5'd1;
    settle();
    chk("full_no_bypass", 32'(ISSUE_READY), 32'd0);
    tick();
    WB_VALID = 0;
    settle();
    chk("full_inflight7", 32'(INFLIGHT), 32'd7);
    chk("full_nostall", 32'({STALL_RAW, STALL_WAW}), 32'd0);
    chk("full_ready1", 32'(ISSUE_READY), 32'd1);
    tick();
    idle();
    chk("full_inflight_back8", 32'(INFLIGHT), 32'd8);
    for (int i = 2; i <= 9; i++) begin
      WB_VALID = 1; WB_NUM = 5'(i);
      tick();
    end
    idle();
    chk("full_drained", 32'(INFLIGHT), 32'd0);

    // 4 fence drain
    ins(0, 5'd0, 5'd0, 1, 0, 5'd10);
    tick();
    ins(1, 5'd1, 5'd1, 0, 1, 5'd6);
    tick();
    idle();
    chk("fence_inflight2", 32'(INFLIGHT), 32'd2);
    ISSUE_VALID = 1; ISSUE_FENCE = 1;
    settle();
    chk("fence_ready0", 32'(ISSUE_READY), 32'd0);
    tick();
    chk("fence_drain_ready0", 32'(ISSUE_READY), 32'd0);
    tick();
    chk("fence_drain_hold", 32'(ISSUE_READY), 32'd0);
    WB_VALID = 1; WB_NUM = 5'd10; FWB_VALID = 1; FWB_NUM = 5'd6;
    tick();
    WB_VALID = 0; FWB_VALID = 0;
    settle();
    chk("fence_inflight0", 32'(INFLIGHT), 32'd0);
    chk("fence_bubble", 32'(ISSUE_READY), 32'd0);
    tick();
    chk("fence_accept", 32'(ISSUE_READY), 32'd1);
    tick();
    idle();
    chk("fence_err", 32'(SB_ERR), 32'd0);

    // 5 writeback to x5 while issuing rd=x5
    ins(0, 5'd0, 5'd0, 1, 0, 5'd5);
    tick();
    chk("col_inflight1", 32'(INFLIGHT), 32'd1);
    WB_VALID = 1; WB_NUM = 5'd5;
    settle();
    chk("col_waw_no_bypass", 32'(ISSUE_READY), 32'd0);
    tick();
    WB_VALID = 0;
    settle();
    chk("col_stall_waw", 32'(STALL_WAW), 32'd1);
    chk("col_inflight0", 32'(INFLIGHT), 32'd0);
    chk("col_ready1", 32'(ISSUE_READY), 32'd1);
    tick();
    ins(0, 5'd5, 5'd0, 1, 0, 5'd6);
    settle();
    chk("col_x5_busy", 32'(ISSUE_READY), 32'd0);
    chk("col_inflight_restored", 32'(INFLIGHT), 32'd1);
    idle();
    WB_VALID = 1; WB_NUM = 5'd5;
    tick();
    idle();
    chk("col_drained", 32'(INFLIGHT), 32'd0);
    chk("col_err", 32'(SB_ERR), 32'd0);

    // 6 x0 and errors; f0 is ordinary
    ins(0, 5'd0, 5'd0, 1, 0, 5'd0);
    settle();
    chk("x0_ready", 32'(ISSUE_READY), 32'd1);
    tick();
    idle();
    chk("x0_nocount", 32'(INFLIGHT), 32'd0);
    WB_VALID = 1; WB_NUM = 5'd0;
    tick();
    chk("x0_wb_silent", 32'(SB_ERR), 32'd0);
    ins(1, 5'd1, 5'd2, 0, 1, 5'd0);
    WB_VALID = 0;
    tick();
    chk("f0_counts", 32'(INFLIGHT), 32'd1);
    ins(1, 5'd0, 5'd1, 0, 1, 5'd2);
    settle();
    chk("f0_hazard", 32'(ISSUE_READY), 32'd0);
    idle();
    FWB_VALID = 1; FWB_NUM = 5'd0;
    tick();
    idle();
    chk("f0_freed", 32'(INFLIGHT), 32'd0);
    WB_VALID = 1; WB_NUM = 5'd7;
    tick();
    idle();
    chk("err_set", 32'(SB_ERR), 32'd1);
    chk("err_nocount", 32'(INFLIGHT), 32'd0);
    tick();
    chk("err_sticky", 32'(SB_ERR), 32'd1);
    RST_N = 0;
    tick();
    RST_N = 1;
    chk("err_reset", 32'(SB_ERR), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
